// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// mc_control -- multicycle MIPS-style control unit (FETCH/DECODE/EXEC/WB FSM)
// Rev 1.0 -- initial release
// ============================================================================
module mc_control #(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zf,
  input  logic                mem_ready,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_zero,
  output logic                pc_we,
  output logic                ir_we,
  output logic                reg_we,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                iord,
  output logic [1:0]          pc_src,
  output logic                mem_req,
  output logic                mem_we,
  output logic [3:0]          state,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd15
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'h00);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'h05);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h08);
  localparam logic [OPCODE_W-1:0] OP_ADDIU= OPCODE_W'(6'h09);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'h0C);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'h0D);
  localparam logic [OPCODE_W-1:0] OP_XORI = OPCODE_W'(6'h0E);
  localparam logic [OPCODE_W-1:0] OP_LUI  = OPCODE_W'(6'h0F);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h23);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h2B);

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_SHL  = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SHRL = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_SHRA = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_LU   = ALUOP_W'(9);

  state_e               state_q, state_d;
  logic [ALUOP_W-1:0]   w_r_aluop;
  logic                 w_r_legal;
  logic                 w_r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // funct is stable through R_WB, so the same decode serves both R states
  always_comb begin
    w_r_aluop = ALU_ADD;
    w_r_legal = 1'b1;
    w_r_shift = 1'b0;
    case (funct)
      FUNCT_W'(6'h20), FUNCT_W'(6'h21): w_r_aluop = ALU_ADD;
      FUNCT_W'(6'h22), FUNCT_W'(6'h23): w_r_aluop = ALU_SUB;
      FUNCT_W'(6'h24): w_r_aluop = ALU_AND;
      FUNCT_W'(6'h25): w_r_aluop = ALU_OR;
      FUNCT_W'(6'h26): w_r_aluop = ALU_XOR;
      FUNCT_W'(6'h27): w_r_aluop = ALU_NOR;
      FUNCT_W'(6'h00): begin w_r_aluop = ALU_SHL;  w_r_shift = 1'b1; end
      FUNCT_W'(6'h02): begin w_r_aluop = ALU_SHRL; w_r_shift = 1'b1; end
      FUNCT_W'(6'h03): begin w_r_aluop = ALU_SHRA; w_r_shift = 1'b1; end
      default:         w_r_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    aluop      = ALU_ADD;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    ext_zero   = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    iord       = 1'b0;
    pc_src     = 2'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_R:                         state_d = S_R_EXEC;
          OP_ADDI, OP_ADDIU, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI:      state_d = S_I_EXEC;
          OP_LW, OP_SW:                 state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:               state_d = S_BRANCH;
          OP_J:                         state_d = S_JUMP;
          default:                      state_d = S_HALT;
        endcase
      end
      S_R_EXEC: begin
        if (w_r_legal) begin
          aluop     = w_r_aluop;
          alu_src_a = w_r_shift ? 2'd2 : 2'd1;
          state_d   = S_R_WB;
        end else begin
          state_d   = S_HALT;
        end
      end
      S_R_WB: begin
        aluop   = w_r_aluop;
        reg_we  = 1'b1;
        reg_dst = 1'b1;
        state_d = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        case (opcode)
          OP_ANDI: begin aluop = ALU_AND; ext_zero = 1'b1; end
          OP_ORI:  begin aluop = ALU_OR;  ext_zero = 1'b1; end
          OP_XORI: begin aluop = ALU_XOR; ext_zero = 1'b1; end
          OP_LUI:  aluop = ALU_LU;
          default: aluop = ALU_ADD;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        aluop     = ALU_SUB;
        alu_src_a = 2'd1;
        pc_src    = 2'd1;
        pc_we     = (opcode == OP_BNE) ? ~zf : zf;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_we   = 1'b1;
        pc_src  = 2'd2;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // state is already forced to FETCH by rst; also mask FETCH's own request
    if (rst) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  assign state   = state_q;
  assign illegal = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// tb_mc_control -- directed scenarios plus randomized instruction streams
// checked against an instruction-level trace model. Rev 1.0
// ============================================================================
module tb_mc_control;
  logic       clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zf = 1'b0, mem_ready = 1'b0;
  logic [3:0] aluop, state;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic       ext_zero, pc_we, ir_we, reg_we, reg_dst, mem_to_reg, iord;
  logic       mem_req, mem_we, illegal;
  int         n_cmp = 0, n_err = 0;

  typedef struct packed {
    logic [3:0] st;  logic [3:0] alu; logic [1:0] sa; logic [1:0] sb;
    logic ez; logic pcw; logic irw; logic rw; logic rd; logic m2r; logic io;
    logic [1:0] ps; logic mq; logic mw; logic ill;
  } obs_t;
  typedef struct { logic mr; obs_t e; } step_t;

  obs_t  obs;
  step_t q[$];

  assign obs = {state, aluop, alu_src_a, alu_src_b, ext_zero, pc_we, ir_we, reg_we,
                reg_dst, mem_to_reg, iord, pc_src, mem_req, mem_we, illegal};

  always #5 clk = ~clk;

  mc_control #(.OPCODE_W(6), .FUNCT_W(6), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zf(zf),
    .mem_ready(mem_ready), .aluop(aluop), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .pc_we(pc_we), .ir_we(ir_we),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .iord(iord),
    .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we), .state(state),
    .illegal(illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t blank(input logic [3:0] s);
    obs_t o = '0;
    o.st  = s;
    o.ill = (s == 4'd15);
    return o;
  endfunction

  // Expected per-cycle trace of one whole instruction, built from its class.
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm);
    obs_t o; logic [3:0] a; bit ok, sh;
    for (int i = 0; i <= wf; i++) begin
      o = blank(4'd0); o.mq = 1'b1; o.sb = 2'd1;
      if (i == wf) begin o.irw = 1'b1; o.pcw = 1'b1; end
      q.push_back('{(i == wf), o});
    end
    o = blank(4'd1); o.sb = 2'd3;
    q.push_back('{1'($urandom_range(0, 1)), o});
    case (op)
      6'h00: begin
        ok = 1'b1; sh = 1'b0; a = 4'd0;
        case (fn)
          6'h20, 6'h21: a = 4'd0;
          6'h22, 6'h23: a = 4'd1;
          6'h24: a = 4'd2;
          6'h25: a = 4'd3;
          6'h26: a = 4'd4;
          6'h27: a = 4'd5;
          6'h00: begin a = 4'd6; sh = 1'b1; end
          6'h02: begin a = 4'd7; sh = 1'b1; end
          6'h03: begin a = 4'd8; sh = 1'b1; end
          default: ok = 1'b0;
        endcase
        o = blank(4'd6);
        if (ok) begin o.alu = a; o.sa = sh ? 2'd2 : 2'd1; end
        q.push_back('{1'($urandom_range(0, 1)), o});
        if (ok) begin
          o = blank(4'd7); o.alu = a; o.rw = 1'b1; o.rd = 1'b1;
          q.push_back('{1'($urandom_range(0, 1)), o});
        end
      end
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        o = blank(4'd8); o.sa = 2'd1; o.sb = 2'd2;
        o.alu = (op == 6'h0C) ? 4'd2 : (op == 6'h0D) ? 4'd3 :
                (op == 6'h0E) ? 4'd4 : (op == 6'h0F) ? 4'd9 : 4'd0;
        o.ez  = (op >= 6'h0C && op <= 6'h0E);
        q.push_back('{1'($urandom_range(0, 1)), o});
        o = blank(4'd9); o.rw = 1'b1;
        q.push_back('{1'($urandom_range(0, 1)), o});
      end
      6'h23, 6'h2B: begin
        o = blank(4'd2); o.sa = 2'd1; o.sb = 2'd2;
        q.push_back('{1'($urandom_range(0, 1)), o});
        for (int i = 0; i <= wm; i++) begin
          o = blank((op == 6'h23) ? 4'd3 : 4'd5); o.mq = 1'b1; o.io = 1'b1;
          o.mw = (op == 6'h2B);
          q.push_back('{(i == wm), o});
        end
        if (op == 6'h23) begin
          o = blank(4'd4); o.rw = 1'b1; o.m2r = 1'b1;
          q.push_back('{1'($urandom_range(0, 1)), o});
        end
      end
      6'h04, 6'h05: begin
        o = blank(4'd10); o.alu = 4'd1; o.sa = 2'd1; o.ps = 2'd1;
        o.pcw = (op == 6'h04) ? z : ~z;
        q.push_back('{1'($urandom_range(0, 1)), o});
      end
      6'h02: begin
        o = blank(4'd11); o.pcw = 1'b1; o.ps = 2'd2;
        q.push_back('{1'($urandom_range(0, 1)), o});
      end
      default: ;
    endcase
    if (q[$].e.st == 4'd6 || q[$].e.st == 4'd1)
      for (int i = 0; i < 3; i++) q.push_back('{1'($urandom_range(0, 1)), blank(4'd15)});
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #2;
    n_cmp++;
    if ({state, illegal, pc_we, ir_we, reg_we, mem_req, mem_we} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs got st=%0d ill=%b en=%b%b%b%b%b want all 0", state, illegal,
               pc_we, ir_we, reg_we, mem_req, mem_we);
    end
    #10; rst = 1'b0; mem_ready = 1'b0;
    tick(); tick();
    n_cmp++;
    if (state !== 4'd0 || mem_req !== 1'b1 || ir_we !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_hold got st=%0d mem_req=%b ir_we=%b want 0/1/0", state, mem_req, ir_we);
    end
  endtask

  task automatic test_add();
    int exp_st[4] = '{0, 1, 6, 7};
    opcode = 6'h00; funct = 6'h20; zf = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (state !== 4'(exp_st[i]) || reg_we !== (i == 3) || (i == 3 && reg_dst !== 1'b1) ||
          (i == 2 && aluop !== 4'd0)) begin
        n_err++;
        $display("FAIL add_step%0d got st=%0d reg_we=%b reg_dst=%b aluop=%0d want st=%0d",
                 i, state, reg_we, reg_dst, aluop, exp_st[i]);
      end
      tick();
    end
    mem_ready = 1'b0; #1;
    n_cmp++;
    if (state !== 4'd0) begin n_err++; $display("FAIL add_return got st=%0d want 0", state); end
  endtask

  task automatic test_lw_wait();
    int   exp_st[7] = '{0, 1, 2, 3, 3, 3, 4};
    logic mr[7]     = '{1, 1, 1, 0, 0, 1, 0};
    opcode = 6'h23; funct = 6'h11;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i]; #1;
      n_cmp++;
      if (state !== 4'(exp_st[i]) || (i >= 3 && i <= 5 && {mem_req, iord, reg_we} !== 3'b110) ||
          (i == 6 && {reg_we, mem_to_reg} !== 2'b11)) begin
        n_err++;
        $display("FAIL lw_step%0d got st=%0d mem_req=%b iord=%b reg_we=%b m2r=%b want st=%0d",
                 i, state, mem_req, iord, reg_we, mem_to_reg, exp_st[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[4] = '{6'h04, 6'h05, 6'h04, 6'h05};
    logic       zs[4]  = '{1, 1, 0, 0};
    logic       pw[4]  = '{1, 0, 0, 1};
    for (int c = 0; c < 4; c++) begin
      opcode = ops[c]; zf = zs[c]; mem_ready = 1'b1;
      tick(); tick();
      mem_ready = 1'b0; #1;
      n_cmp++;
      if (state !== 4'd10 || pc_we !== pw[c] || pc_src !== 2'd1 || aluop !== 4'd1) begin
        n_err++;
        $display("FAIL branch_op%h_zf%b got st=%0d pc_we=%b pc_src=%0d aluop=%0d want 10/%b/1/1",
                 ops[c], zs[c], state, pc_we, pc_src, aluop, pw[c]);
      end
      tick();
    end
  endtask

  task automatic test_itype();
    logic [5:0] ops[2] = '{6'h0D, 6'h0F};
    logic [3:0] al[2]  = '{4'd3, 4'd9};
    logic       ez[2]  = '{1, 0};
    for (int c = 0; c < 2; c++) begin
      opcode = ops[c]; mem_ready = 1'b1;
      tick(); tick();
      #1;
      n_cmp++;
      if (state !== 4'd8 || aluop !== al[c] || ext_zero !== ez[c] || alu_src_b !== 2'd2) begin
        n_err++;
        $display("FAIL iexec_op%h got st=%0d aluop=%0d ez=%b want 8/%0d/%b", ops[c], state,
                 aluop, ext_zero, al[c], ez[c]);
      end
      tick();
      mem_ready = 1'b0; #1;
      n_cmp++;
      if (state !== 4'd9 || reg_we !== 1'b1 || reg_dst !== 1'b0) begin
        n_err++;
        $display("FAIL iwb_op%h got st=%0d reg_we=%b reg_dst=%b want 9/1/0", ops[c], state,
                 reg_we, reg_dst);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    opcode = 6'h3F; mem_ready = 1'b1;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom_range(0, 1)); #1;
      n_cmp++;
      if (state !== 4'd15 || illegal !== 1'b1 ||
          {pc_we, ir_we, reg_we, mem_req, mem_we} !== 5'b0) begin
        n_err++;
        $display("FAIL halt_cycle%0d got st=%0d ill=%b en=%b%b%b%b%b want 15/1/00000", i, state,
                 illegal, pc_we, ir_we, reg_we, mem_req, mem_we);
      end
      tick();
    end
    rst = 1'b1; #1;
    n_cmp++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL halt_reset got st=%0d ill=%b want 0/0", state, illegal);
    end
    #1; rst = 1'b0; mem_ready = 1'b0;
    tick();
  endtask

  task automatic test_memwr_reset();
    opcode = 6'h2B; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    n_cmp++;
    if (state !== 4'd5 || mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL memwr_wait got st=%0d mem_we=%b want 5/1", state, mem_we);
    end
    #2; rst = 1'b1; #1;
    n_cmp++;
    if (state !== 4'd0 || mem_we !== 1'b0 || mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL memwr_reset got st=%0d mem_we=%b mem_req=%b want 0/0/0", state, mem_we, mem_req);
    end
    #1; rst = 1'b0;
    tick();
    n_cmp++;
    if (state !== 4'd0 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL memwr_abandon got st=%0d mem_we=%b want 0/0", state, mem_we);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[12] = '{6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                            6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    logic [5:0] fns[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h00, 6'h02, 6'h03};
    logic [5:0] op, fn;
    logic       z;
    int         r;
    for (int n = 0; n < 150; n++) begin
      r  = int'($urandom_range(0, 14));
      op = (r < 12) ? ops[r] : 6'($urandom);
      r  = int'($urandom_range(0, 13));
      fn = (r < 11) ? fns[r] : 6'($urandom);
      z  = 1'($urandom);
      q.delete();
      model(op, fn, z, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      opcode = op; funct = fn; zf = z;
      foreach (q[k]) begin
        mem_ready = q[k].mr; #1;
        n_cmp++;
        if (obs !== q[k].e) begin
          n_err++;
          $display("FAIL random_%0d_step%0d op=%h fn=%h zf=%b got=%h want=%h", n, k, op, fn, z,
                   obs, q[k].e);
        end
        tick();
      end
      if (q[$].e.st == 4'd15) begin
        rst = 1'b1; #2; rst = 1'b0; mem_ready = 1'b0;
        tick();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_itype();
    test_halt();
    test_memwr_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter OPCODE_W, 6, instruction opcode field width.
REQ-002 Parameter FUNCT_W, 6, R-type funct field width.
REQ-003 Parameter ALUOP_W, 4, width of the ALU operation code driven to the ALU.
REQ-004 clk  in  1  the single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 opcode  in  OPCODE_W  IR[31:26]; the datapath holds it stable from DECODE until the next IR write.
REQ-007 funct  in  FUNCT_W  IR[5:0]; same stability as opcode.
REQ-008 zf  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  memory completes the current request this cycle.
REQ-010 aluop  out  ALUOP_W  encoding ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SHL=6, SHRL=7, SHRA=8, LU=9.
REQ-011 alu_src_a  out  2  0=PC, 1=rs, 2=shamt.
REQ-012 alu_src_b  out  2  0=rt, 1=const 4, 2=extended imm, 3=sign-extended imm<<2.
REQ-013 ext_zero  out  1  imm extension: 1=zero-extend, 0=sign-extend.
REQ-014 Write enables and selects, all out 1: pc_we, ir_we, reg_we, reg_dst (1=rd, 0=rt), mem_to_reg, iord (1=ALUOut address, 0=PC).
REQ-015 pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target.
REQ-016 mem_req and mem_we  out  1 each  memory request; write qualifier.
REQ-017 state  out  4  current state code; illegal  out  1  HALT indicator.

Function
REQ-018 State codes SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, HALT=15.
REQ-019 Outputs SHALL be combinational from state, with opcode/funct/zf/mem_ready only where stated; unlisted outputs are 0.
REQ-020 FETCH: mem_req=1, iord=0, aluop=ADD, src_a=0, src_b=1. With mem_ready=1, also ir_we=1, pc_we=1, pc_src=0, next DECODE. Otherwise hold FETCH indefinitely.
REQ-021 DECODE: aluop=ADD, src_a=0, src_b=3 (branch target into ALUOut).
REQ-022 DECODE next state by opcode:
- 0x00 -> R_EXEC.
- 0x08/0x09/0x0C/0x0D/0x0E/0x0F -> I_EXEC.
- 0x23/0x2B -> MEM_ADDR.
- 0x04/0x05 -> BRANCH.
- 0x02 -> JUMP.
- any other -> HALT.
REQ-023 R_EXEC funct map: 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, src_a=1, src_b=0; 0x00 SHL, 0x02 SHRL, 0x03 SHRA with src_a=2, src_b=0; next R_WB; unlisted funct -> HALT with no writes.
REQ-024 R_WB: reg_we=1, reg_dst=1, mem_to_reg=0, aluop held from R_EXEC decode; next FETCH.
REQ-025 I_EXEC: src_a=1, src_b=2; 0x08/0x09 ADD ext_zero=0; 0x0C AND, 0x0D OR, 0x0E XOR with ext_zero=1; 0x0F LU; next I_WB.
REQ-026 I_WB: reg_we=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-027 MEM_ADDR: ADD, src_a=1, src_b=2, ext_zero=0; next MEM_RD (0x23) or MEM_WR (0x2B).
REQ-028 MEM_RD: mem_req=1, iord=1; hold until mem_ready, then MEM_WB.
REQ-029 MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1; next FETCH.
REQ-030 MEM_WR: mem_req=1, mem_we=1, iord=1; hold until mem_ready, then FETCH.
REQ-031 BRANCH: SUB, src_a=1, src_b=0, pc_src=1, pc_we = zf for beq (0x04), ~zf for bne (0x05); next FETCH.
REQ-032 JUMP: pc_we=1, pc_src=2; next FETCH.
REQ-033 HALT: illegal=1, all enables and mem_req 0; remain until reset.
REQ-034 Latency:
- R/I-type: 4 cycles.
- sw: 4 cycles.
- lw: 5 cycles.
- beq/bne and j: 3 cycles.
- Each memory access adds one cycle per mem_ready-low cycle.

Reset
REQ-035 rst=1 SHALL asynchronously force state=FETCH and illegal=0.
REQ-036 While rst=1, pc_we, ir_we, reg_we, mem_req and mem_we SHALL be 0.
REQ-037 Reset mid-instruction, including while waiting on mem_ready, SHALL abandon the instruction with no further writes.

Verification
REQ-038 add (opcode 0, funct 0x20), mem_ready=1 -> states 0,1,6,7,0; aluop=0 in R_EXEC; reg_we=1 only in R_WB with reg_dst=1.
REQ-039 lw with mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, then MEM_WB with reg_we=1, mem_to_reg=1.
REQ-040 beq with zf=1 -> pc_we=1, pc_src=1 in BRANCH; bne with zf=1 -> pc_we=0.
REQ-041 ori (0x0D) -> I_EXEC aluop=3, ext_zero=1; lui -> aluop=9.
REQ-042 opcode 0x3F -> HALT, illegal=1, no enables for 10 cycles; rst pulse -> FETCH.
REQ-043 rst asserted mid-clock during MEM_WR -> immediate state=0, mem_we=0.
